instruction_fetch: RTL

Fetch stage of the MIPS datapath. Holds the program counter, issues word reads to instruction memory over a request/grant port, and buffers returned words in a small FIFO. It presents one instruction per cycle, together with its PC, to the field decoder over a valid/ready handshake. It accepts jump/branch redirects from later stages and flushes all wrong-path work.

---
 rtl/mips_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 48 ++++
 rtl/instruction_fetch.sv | 92 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and constants used by the fetch stage.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_INCR  = 32'd4;
  localparam logic [WORD_W-1:0] INST_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] word;
  } fetch_entry_t;

  function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, word} fetch entries with a flush input.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // Wrap explicitly so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_reg[wr_ptr_reg] <= push_data;
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC generation, credit-limited instruction memory requests,
// response buffering and redirect flushing of wrong-path work.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [WORD_W-1:0] instruction,
  output logic [WORD_W-1:0] inst_pc,
  output logic [WORD_W-1:0] inst_pc_plus4
);

  localparam int              CNT_W      = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]  CREDIT_MAX = (CNT_W + 1)'(DEPTH);

  logic [WORD_W-1:0] fetch_pc_reg;
  logic [WORD_W-1:0] resp_pc_reg;
  logic [CNT_W-1:0]  outstanding_reg;
  logic [CNT_W-1:0]  drop_reg;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_used;
  logic              transfer;
  logic              pop;
  logic              push;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  assign pop = inst_valid & inst_ready;

  // A slot freed by this cycle's pop can be re-requested immediately.
  assign credit_used = {1'b0, outstanding_reg} + {1'b0, fifo_count} - {{CNT_W{1'b0}}, pop};
  assign imem_req    = !reset && !redirect_valid && (credit_used < CREDIT_MAX);
  assign imem_addr   = fetch_pc_reg;
  assign transfer    = imem_req & imem_gnt;

  assign push       = imem_rvalid && !redirect_valid && (drop_reg == '0);
  assign push_entry = {resp_pc_reg, imem_rdata};

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      drop_reg        <= '0;
    end else begin
      outstanding_reg <= outstanding_reg + CNT_W'(transfer) - CNT_W'(imem_rvalid);
      if (redirect_valid) begin
        fetch_pc_reg <= align_pc(redirect_pc);
        resp_pc_reg  <= align_pc(redirect_pc);
        // Every response still in flight belongs to the wrong path.
        drop_reg     <= outstanding_reg - CNT_W'(imem_rvalid);
      end else begin
        if (transfer) fetch_pc_reg <= fetch_pc_reg + PC_INCR;
        if (imem_rvalid) begin
          if (drop_reg != '0) drop_reg <= drop_reg - CNT_W'(1);
          else                resp_pc_reg <= resp_pc_reg + PC_INCR;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (fifo_count)
  );

  assign inst_valid    = !reset && (fifo_count != '0);
  assign instruction   = inst_valid ? head_entry.word : INST_NOP;
  assign inst_pc       = inst_valid ? head_entry.pc : '0;
  assign inst_pc_plus4 = inst_pc + PC_INCR;

endmodule
